// File: rtl/ysyx_24110015_ifu_prefetch.sv
// rtl/ysyx_24110015_ifu_prefetch.sv - IFU prefetcher: one-outstanding AXI read fetcher feeding an instruction FIFO
// Optional feature macro: YSYX_24110015_IFU_DELAY_EN (pseudo-random IDLE->AR delay)
module ysyx_24110015_ifu_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              drop_pend_q, drop_pend_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              err_mem  [DEPTH];

  logic ar_hs, r_hs, push, pop, delay_ok, can_fetch;

`ifdef YSYX_24110015_IFU_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] delay_q, delay_d;

  // Free-running LFSR; reload the delay on every IDLE entry, count it down while idling
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    delay_d = delay_q;
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      delay_d = lfsr_q[3:0];
    end else if (state_q == S_IDLE && delay_q != 4'd0) begin
      delay_d = delay_q - 4'd1;
    end
  end

  // Delay generator state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= 8'h01;
      delay_q <= 4'h1;
    end else begin
      lfsr_q  <= lfsr_d;
      delay_q <= delay_d;
    end
  end

  assign delay_ok = (delay_q == 4'd0);
`else
  assign delay_ok = 1'b1;
`endif

  assign ar_hs     = arvalid_q && arready;
  assign r_hs      = rready_q && rvalid;
  assign push      = (state_q == S_R) && r_hs && !redirect_valid;
  assign pop       = (count_q != '0) && inst_ready && !redirect_valid;
  assign can_fetch = (count_q < CNT_W'(DEPTH)) && !redirect_valid && delay_ok;

  // Fetch FSM next state; a redirect seen in AR is remembered so the response gets dropped
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    araddr_d    = araddr_q;
    drop_pend_d = drop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (can_fetch) begin
          state_d  = S_AR;
          araddr_d = fetch_pc_q;
        end
      end
      S_AR: begin
        if (redirect_valid) drop_pend_d = 1'b1;
        if (ar_hs) begin
          state_d     = (drop_pend_q || redirect_valid) ? S_DROP : S_R;
          drop_pend_d = 1'b0;
        end
      end
      S_R: begin
        // A response consumed in the redirect cycle is simply discarded
        if (r_hs) begin
          state_d = S_IDLE;
          if (!redirect_valid) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (r_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R) || (state_d == S_DROP);
  end

  // FIFO pointer/occupancy update; redirect flushes and overrides any pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      araddr_q    <= RESET_PC;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      drop_pend_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      drop_pend_q <= drop_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= rdata;
      err_mem[wr_ptr_q]  <= |rresp;
    end
  end

  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem[rd_ptr_q];
  assign pc         = pc_mem[rd_ptr_q];
  assign inst_err   = err_mem[rd_ptr_q];

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// tb/tb_ysyx_24110015_ifu_prefetch.sv - self-checking bench for ysyx_24110015_ifu_prefetch
module tb_ysyx_24110015_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  ysyx_24110015_ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .inst_err(inst_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory / slave model state
  bit          slave_busy;
  logic [31:0] req_addr;
  int          lat_cnt;
  int          max_lat;
  bit          data_mode;
  bit          err_rand;
  logic [31:0] err_pc;

  // program-order reference: next pc the IDU must see
  logic [31:0] exp_pc;
  int          n_ar, n_pop, n_err_pop;

  logic        drv_arready, drv_inst_ready, drv_redirect;
  logic [31:0] drv_redirect_pc;

  typedef struct {
    logic        arready;
    logic        inst_ready;
    logic        exp_arvalid;
    logic [31:0] exp_araddr;
    logic        exp_rready;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (data_mode) return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    return 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_pc) || (err_rand && a[4:2] == 3'd5);
  endfunction

  task automatic clear_models();
    slave_busy = 0; lat_cnt = 0; req_addr = '0;
    exp_pc = RESET_PC; n_ar = 0; n_pop = 0; n_err_pop = 0;
    drv_arready = 0; drv_inst_ready = 0; drv_redirect = 0; drv_redirect_pc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
    clear_models();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at the negedge, score the handshakes the next posedge will see
  task automatic step();
    logic rv, ar_hs, r_hs, pop, redir;
    rv = slave_busy && (lat_cnt == 0);
    if (slave_busy && lat_cnt != 0) lat_cnt--;
    arready        = drv_arready;
    rvalid         = rv;
    rdata          = rv ? mem_data(req_addr) : 32'hDEAD_BEEF;
    rresp          = (rv && mem_err(req_addr)) ? 2'b10 : 2'b00;
    inst_ready     = drv_inst_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    redir          = drv_redirect;
    if (arvalid) chk("one_outstanding", slave_busy, 0);
    ar_hs = arvalid && drv_arready;
    r_hs  = rready && rv;
    pop   = inst_valid && drv_inst_ready && !redir;
    if (pop) begin
      chk("pop_pc", pc, exp_pc);
      chk("pop_inst", inst, mem_data(exp_pc));
      chk("pop_err", inst_err, mem_err(exp_pc));
      if (inst_err) n_err_pop++;
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redir) exp_pc = drv_redirect_pc;
    if (r_hs) slave_busy = 0;
    if (ar_hs) begin
      slave_busy = 1;
      req_addr   = araddr;
      lat_cnt    = (max_lat == 0) ? 0 : int'($urandom_range(0, max_lat));
      n_ar++;
    end
    @(posedge clk);
    @(negedge clk);
    drv_redirect = 0;
    if (redir) chk("flush_after_redirect", inst_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0000};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008};

    data_mode = 0; err_rand = 0; err_pc = 32'hFFFF_FFF0; max_lat = 0;

    // Reset values and steady 3-cycle fetch rhythm
    do_reset();
    chk("reset_araddr", araddr, RESET_PC);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_arvalid", i), arvalid, tbl[i].exp_arvalid);
      chk($sformatf("vec%0d_rready", i), rready, tbl[i].exp_rready);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, tbl[i].exp_iv);
      if (tbl[i].exp_arvalid) chk($sformatf("vec%0d_araddr", i), araddr, tbl[i].exp_araddr);
      if (tbl[i].exp_iv) begin
        chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d_inst", i), inst, 32'h0000_0013);
      end
      drv_arready    = tbl[i].arready;
      drv_inst_ready = tbl[i].inst_ready;
      step();
    end
    chk("table_pops", n_pop, 3);

    // Back-pressure: FIFO fills with exactly DEPTH fetches
    do_reset();
    drv_arready = 1; drv_inst_ready = 0;
    repeat (40) step();
    chk("full_ar_count", n_ar, 4);
    chk("full_arvalid", arvalid, 0);
    chk("full_inst_valid", inst_valid, 1);
    chk("full_head_pc", pc, RESET_PC);
    drv_inst_ready = 1;
    step();
    drv_inst_ready = 0;
    repeat (20) step();
    chk("refill_ar_count", n_ar, 5);
    chk("refill_arvalid", arvalid, 0);
    chk("refill_head_pc", pc, 32'h8000_0004);

    // Redirect while in R with rvalid in the same cycle
    do_reset();
    drv_arready = 1; drv_inst_ready = 0;
    for (int i = 0; i < 50 && !(rready && n_ar == 3); i++) step();
    chk("r_redirect_reach_r", rready, 1);
    chk("r_redirect_fifo_busy", inst_valid, 1);
    drv_redirect = 1; drv_redirect_pc = 32'h8000_0100;
    step();
    for (int i = 0; i < 20 && !arvalid; i++) step();
    chk("r_redirect_arvalid", arvalid, 1);
    chk("r_redirect_araddr", araddr, 32'h8000_0100);
    drv_inst_ready = 1;
    repeat (10) step();
    chk("r_redirect_progress", n_pop >= 1, 1);

    // Redirect while AR is stalled by arready
    do_reset();
    drv_arready = 0; drv_inst_ready = 0;
    for (int i = 0; i < 10 && !arvalid; i++) step();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin drv_redirect = 1; drv_redirect_pc = 32'h8000_0200; end
      step();
      chk("ar_stall_arvalid", arvalid, 1);
      chk("ar_stall_araddr", araddr, RESET_PC);
    end
    drv_arready = 1;
    step();
    chk("ar_drop_arvalid", arvalid, 0);
    chk("ar_drop_rready", rready, 1);
    step();
    chk("ar_drop_no_push", inst_valid, 0);
    for (int i = 0; i < 20 && !arvalid; i++) step();
    chk("ar_redirect_araddr", araddr, 32'h8000_0200);
    drv_inst_ready = 1;
    repeat (8) step();
    chk("ar_redirect_progress", n_pop >= 1, 1);

    // Error response flagged on exactly one entry
    do_reset();
    data_mode = 1; err_pc = 32'h8000_0004;
    drv_arready = 1; drv_inst_ready = 1;
    repeat (15) step();
    chk("err_pops", n_pop, 4);
    chk("err_count", n_err_pop, 1);
    data_mode = 0; err_pc = 32'hFFFF_FFF0;

    // Reset pulse in the middle of an R phase
    do_reset();
    drv_arready = 1; drv_inst_ready = 0;
    for (int i = 0; i < 30 && !(rready && n_ar == 2); i++) step();
    chk("rst_reach_r", rready, 1);
    rst = 1'b1;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_araddr", araddr, RESET_PC);
    clear_models();
    rvalid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv_arready = 1;
    step();
    chk("rst_restart_arvalid", arvalid, 1);
    chk("rst_restart_araddr", araddr, RESET_PC);
    drv_inst_ready = 1;
    repeat (6) step();
    chk("rst_restart_progress", n_pop >= 1, 1);

    // Randomized traffic against the program-order reference
    do_reset();
    data_mode = 1; err_rand = 1; max_lat = 3;
    for (int c = 0; c < 4000; c++) begin
      drv_arready    = ($urandom_range(0, 9) < 7);
      drv_inst_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) < 3) begin
        drv_redirect    = 1;
        drv_redirect_pc = 32'h8000_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      step();
    end
    chk("random_progress", n_pop > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_ifu_prefetch.md
YSYX_24110015_IFU_PREFETCH -- requirements
Module: ysyx_24110015_ifu_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock; one clock domain, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- redirect_valid  in  1  flush and restart fetch (from WBU).
- redirect_pc  in  ADDR_W  new fetch address.
- inst_valid  out  1  FIFO head valid (to IDU).
- inst_ready  in  1  IDU accepts head.
- inst  out  DATA_W  head instruction.
- pc  out  ADDR_W  head instruction address.
- inst_err  out  1  head fetched with rresp != 0.
- araddr  out  ADDR_W  AXI AR address.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rdata  in  DATA_W  AXI R data.
- rresp  in  2  AXI R response.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Function
REQ-006 SHALL keep at most one outstanding AXI read.
REQ-007 SHALL implement FSM IDLE, AR, R, DROP.
REQ-008 IDLE: if occupancy < DEPTH and no redirect_valid (and delay expired, REQ-023), next state AR.
REQ-009 AR: arvalid=1, araddr=fetch_pc, both stable until arvalid&arready; on handshake -> R.
REQ-010 R: rready=1; on rvalid&rready push {fetch_pc, rdata, |rresp} into FIFO, fetch_pc += 4 (wraps modulo 2^ADDR_W), -> IDLE.
REQ-011 DROP: rready=1; on rvalid&rready discard data, no push, -> IDLE.
REQ-012 rready SHALL be 0 in IDLE and AR; arvalid SHALL be 0 outside AR.
REQ-013 redirect_valid in any state: FIFO flushed (occupancy 0 next cycle), fetch_pc <= redirect_pc.
REQ-014 redirect in AR: stay in AR (arvalid/araddr unchanged) until handshake, then -> DROP.
REQ-015 redirect in R: -> DROP, no push even if rvalid same cycle.
REQ-016 redirect in DROP: stay DROP; redirect in IDLE: stay IDLE that cycle.
REQ-017 inst_valid = occupancy != 0; inst/pc/inst_err SHALL reflect head entry combinationally.
REQ-018 pop on inst_valid&inst_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-019 redirect and pop in the same cycle: redirect wins, entry discarded, no double-pop.
REQ-020 FIFO SHALL never overflow; pointers wrap modulo DEPTH; occupancy width clog2(DEPTH)+1.
REQ-021 Latency (delay disabled): reset release -> arvalid 1 cycle; R handshake -> inst_valid next cycle; steady throughput 1 instruction per 3 cycles with arready=1 and rvalid 1 cycle after AR.

Reset
REQ-022 While rst=1: state IDLE, fetch_pc=RESET_PC, FIFO empty, arvalid=0, rready=0, inst_valid=0, araddr=RESET_PC, delay counter reloaded; any in-flight transaction is abandoned.

Configuration
REQ-023 Macro YSYX_24110015_IFU_DELAY_EN defined: 8-bit LFSR (seed 8'h01, advances every cycle) loads a 4-bit delay (LFSR[3:0]) on each IDLE entry; the transition IDLE->AR waits until the counter reaches 0.
REQ-024 Macro undefined: no LFSR or counter, IDLE->AR at the first eligible cycle.

Verification
REQ-025 Reset release, arready=1, rvalid 1 cycle after AR, rdata=32'h0000_0013, inst_ready=1 -> araddr sequence 8000_0000, 8000_0004, 8000_0008; pc/inst match.
REQ-026 inst_ready=0, DEPTH=4 -> exactly 4 AR handshakes, then arvalid stays 0; inst_ready=1 one cycle -> one further fetch.
REQ-027 redirect_valid with redirect_pc=32'h8000_0100 while in R -> response dropped, FIFO empty, next araddr=8000_0100.
REQ-028 arready held 0 for 5 cycles with redirect in cycle 2 -> arvalid/araddr stable, R then DROP, next araddr=redirect_pc.
REQ-029 rresp=2'b10 on a fetch -> entry delivered with inst_err=1, following entries inst_err=0.
REQ-030 rst asserted mid-R for 1 cycle -> arvalid=0, rready=0, inst_valid=0 immediately; restart at 8000_0000.
